// File: rtl/seg_bcd_scan.sv
// Two-digit seven-segment back-end: captures a binary value, converts it to BCD
// (or splits hex nibbles) and time-multiplexes both digits onto the segment bus.
module seg_bcd_scan #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned SCAN_W = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] din,
    input  logic            load,
    input  logic            hex_mode,
    input  logic            blank_lz,
    output logic [7:0]      digit_seg,
    output logic [1:0]      digit_cath,
    output logic            busy,
    output logic            ovf
);

    localparam int unsigned VAL_W  = 8;
    localparam int unsigned ITER_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [7:0] SEG_ZERO  = 8'b11111100;
    localparam logic [7:0] SEG_DASH  = 8'b00000010;
    localparam logic [7:0] SEG_BLANK = 8'b00000000;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'h0: g = 8'b11111100;
            4'h1: g = 8'b01100000;
            4'h2: g = 8'b11011010;
            4'h3: g = 8'b11110010;
            4'h4: g = 8'b01100110;
            4'h5: g = 8'b10110110;
            4'h6: g = 8'b10111110;
            4'h7: g = 8'b11100000;
            4'h8: g = 8'b11111110;
            4'h9: g = 8'b11110110;
            4'hA: g = 8'b11101110;
            4'hB: g = 8'b00111110;
            4'hC: g = 8'b10011100;
            4'hD: g = 8'b01111010;
            4'hE: g = 8'b10011110;
            default: g = 8'b10001110;
        endcase
        return g;
    endfunction

    logic [1:0]        r_state;
    logic [VAL_W-1:0]  r_val;
    logic              r_hex;
    logic [ITER_W-1:0] r_iter;
    logic [3:0]        r_hund;
    logic [3:0]        r_tens;
    logic [3:0]        r_units;
    logic [3:0]        r_disp_tens;
    logic [3:0]        r_disp_units;
    logic              r_ovf;
    logic              r_busy;
    logic [SCAN_W-1:0] r_cnt;
    logic              r_phase;
    logic [7:0]        r_seg;
    logic [1:0]        r_cath;

    logic [1:0]        w_state_nxt;
    logic [VAL_W-1:0]  w_val_nxt;
    logic              w_hex_nxt;
    logic [ITER_W-1:0] w_iter_nxt;
    logic [3:0]        w_hund_nxt;
    logic [3:0]        w_tens_nxt;
    logic [3:0]        w_units_nxt;
    logic [3:0]        w_disp_tens_nxt;
    logic [3:0]        w_disp_units_nxt;
    logic              w_ovf_nxt;
    logic [3:0]        w_hund_adj;
    logic [3:0]        w_tens_adj;
    logic [3:0]        w_units_adj;
    logic [3:0]        w_digit;
    logic [7:0]        w_glyph;

    assign w_hund_adj  = add3(r_hund);
    assign w_tens_adj  = add3(r_tens);
    assign w_units_adj = add3(r_units);

    // Control FSM and double-dabble datapath next-state
    always_comb begin
        w_state_nxt      = r_state;
        w_val_nxt        = r_val;
        w_hex_nxt        = r_hex;
        w_iter_nxt       = r_iter;
        w_hund_nxt       = r_hund;
        w_tens_nxt       = r_tens;
        w_units_nxt      = r_units;
        w_disp_tens_nxt  = r_disp_tens;
        w_disp_units_nxt = r_disp_units;
        w_ovf_nxt        = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_val_nxt   = VAL_W'(din);
                    w_hex_nxt   = hex_mode;
                    w_iter_nxt  = '0;
                    w_hund_nxt  = 4'd0;
                    w_tens_nxt  = 4'd0;
                    w_units_nxt = 4'd0;
                    w_state_nxt = hex_mode ? S_COMMIT : S_CONV;
                end
            end
            S_CONV: begin
                // MSB of the IN_W-wide value feeds the units nibble
                w_hund_nxt  = {w_hund_adj[2:0], w_tens_adj[3]};
                w_tens_nxt  = {w_tens_adj[2:0], w_units_adj[3]};
                w_units_nxt = {w_units_adj[2:0], r_val[IN_W-1]};
                w_val_nxt   = {r_val[VAL_W-2:0], 1'b0};
                w_iter_nxt  = r_iter + ITER_W'(1);
                if (r_iter == ITER_W'(IN_W - 1)) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (r_hex) begin
                    w_disp_tens_nxt  = r_val[7:4];
                    w_disp_units_nxt = r_val[3:0];
                    w_ovf_nxt        = 1'b0;
                end else if (r_hund != 4'd0) begin
                    w_disp_tens_nxt  = 4'd0;
                    w_disp_units_nxt = 4'd0;
                    w_ovf_nxt        = 1'b1;
                end else begin
                    w_disp_tens_nxt  = r_tens;
                    w_disp_units_nxt = r_units;
                    w_ovf_nxt        = 1'b0;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_val        <= '0;
            r_hex        <= 1'b0;
            r_iter       <= '0;
            r_hund       <= 4'd0;
            r_tens       <= 4'd0;
            r_units      <= 4'd0;
            r_disp_tens  <= 4'd0;
            r_disp_units <= 4'd0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_val        <= w_val_nxt;
            r_hex        <= w_hex_nxt;
            r_iter       <= w_iter_nxt;
            r_hund       <= w_hund_nxt;
            r_tens       <= w_tens_nxt;
            r_units      <= w_units_nxt;
            r_disp_tens  <= w_disp_tens_nxt;
            r_disp_units <= w_disp_units_nxt;
            r_ovf        <= w_ovf_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    // Glyph for the digit currently being scanned
    assign w_digit = r_phase ? r_disp_tens : r_disp_units;

    always_comb begin
        w_glyph = glyph(w_digit);
        if (r_ovf) begin
            w_glyph = SEG_DASH;
        end else if (r_phase && blank_lz && (r_disp_tens == 4'd0)) begin
            w_glyph = SEG_BLANK;
        end
    end

    // Segment and cathode registers share one phase so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_seg   <= SEG_ZERO;
            r_cath  <= 2'b01;
        end else begin
            r_cnt  <= r_cnt + SCAN_W'(1);
            r_seg  <= w_glyph;
            r_cath <= r_phase ? 2'b10 : 2'b01;
            if (r_cnt == {SCAN_W{1'b1}}) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign digit_seg  = r_seg;
    assign digit_cath = r_cath;
    assign busy       = r_busy;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Directed bench for seg_bcd_scan with a short scan period (SCAN_W=2).
module tb_seg_bcd_scan;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       load;
    logic       hex_mode;
    logic       blank_lz;
    logic [7:0] digit_seg;
    logic [1:0] digit_cath;
    logic       busy;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    seg_bcd_scan #(.IN_W(8), .SCAN_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load       (load),
        .hex_mode   (hex_mode),
        .blank_lz   (blank_lz),
        .digit_seg  (digit_seg),
        .digit_cath (digit_cath),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to the first sample of a fresh phase showing the wanted cathode
    task automatic seek(input logic [1:0] want, output logic ok);
        int n = 0;
        while (digit_cath === want && n < 20) begin tick(); n++; end
        while (digit_cath !== want && n < 40) begin tick(); n++; end
        ok = (digit_cath === want);
    endtask

    // Strobe a load, count busy samples, then allow one edge for the segment register
    task automatic do_load(input logic [7:0] v, input logic hx, output int nbusy);
        din = v; hex_mode = hx; load = 1'b1;
        tick();
        load = 1'b0; din = 8'hA5;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin nbusy++; tick(); end
        tick();
    endtask

    task automatic test_reset();
        int n;
        logic ok;
        rst = 1'b1; load = 1'b0; din = 8'd0; hex_mode = 1'b0; blank_lz = 1'b0;
        #2;
        checks++; if (digit_seg !== 8'b11111100) begin errors++; $display("FAIL rst_seg got %b exp 11111100", digit_seg); end
        checks++; if (digit_cath !== 2'b01) begin errors++; $display("FAIL rst_cath got %b exp 01", digit_cath); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (digit_cath !== 2'b01) begin errors++; $display("FAIL post_rst_cath got %b exp 01", digit_cath); end
        seek(2'b10, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL scan_seek_tens got %b exp 1", ok); end
        n = 0;
        while (digit_cath === 2'b10 && n < 20) begin n++; tick(); end
        checks++; if (n != 4) begin errors++; $display("FAIL scan_tens_len got %0d exp 4", n); end
        n = 0;
        while (digit_cath === 2'b01 && n < 20) begin n++; tick(); end
        checks++; if (n != 4) begin errors++; $display("FAIL scan_units_len got %0d exp 4", n); end
    endtask

    task automatic test_decimal();
        int nb;
        logic ok;
        blank_lz = 1'b0;
        do_load(8'd30, 1'b0, nb);
        checks++; if (nb != 9) begin errors++; $display("FAIL dec_busy got %0d exp 9", nb); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dec_ovf got %b exp 0", ovf); end
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b11111100) begin errors++; $display("FAIL dec30_units got %b exp 11111100", digit_seg); end
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b11110010) begin errors++; $display("FAIL dec30_tens got %b exp 11110010", digit_seg); end
    endtask

    task automatic test_hex();
        int nb;
        logic ok;
        do_load(8'h1E, 1'b1, nb);
        checks++; if (nb != 1) begin errors++; $display("FAIL hex_busy got %0d exp 1", nb); end
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b01100000) begin errors++; $display("FAIL hex_tens got %b exp 01100000", digit_seg); end
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b10011110) begin errors++; $display("FAIL hex_units got %b exp 10011110", digit_seg); end
    endtask

    task automatic test_blank();
        int nb;
        logic ok;
        blank_lz = 1'b1;
        do_load(8'd7, 1'b0, nb);
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b00000000) begin errors++; $display("FAIL blank_tens got %b exp 00000000", digit_seg); end
        blank_lz = 1'b0;
        tick();
        checks++; if (digit_cath !== 2'b10 || digit_seg !== 8'b11111100) begin errors++; $display("FAIL unblank_tens got %b/%b exp 10/11111100", digit_cath, digit_seg); end
        blank_lz = 1'b1;
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b11100000) begin errors++; $display("FAIL blank_units got %b exp 11100000", digit_seg); end
        blank_lz = 1'b0;
    endtask

    task automatic test_ovf();
        int nb;
        logic ok;
        blank_lz = 1'b1;
        do_load(8'd150, 1'b0, nb);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b00000010) begin errors++; $display("FAIL ovf_tens got %b exp 00000010", digit_seg); end
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b00000010) begin errors++; $display("FAIL ovf_units got %b exp 00000010", digit_seg); end
        blank_lz = 1'b0;
        do_load(8'd42, 1'b0, nb);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b01100110) begin errors++; $display("FAIL dec42_tens got %b exp 01100110", digit_seg); end
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b11011010) begin errors++; $display("FAIL dec42_units got %b exp 11011010", digit_seg); end
    endtask

    task automatic test_back_to_back();
        int nb;
        logic ok;
        din = 8'd25; hex_mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            // Strobe mid-conversion and again on the COMMIT cycle
            if (nb == 3 || nb == 9) begin din = 8'd99; load = 1'b1; end
            tick();
            load = 1'b0;
        end
        checks++; if (nb != 9) begin errors++; $display("FAIL b2b_busy got %0d exp 9", nb); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_requeue got %b exp 0", busy); end
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b11011010) begin errors++; $display("FAIL b2b_tens got %b exp 11011010", digit_seg); end
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b10110110) begin errors++; $display("FAIL b2b_units got %b exp 10110110", digit_seg); end
    endtask

    task automatic test_reset_mid();
        int nb;
        logic ok;
        din = 8'd88; hex_mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        nb = 1;
        while (nb < 4) begin tick(); nb++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (digit_seg !== 8'b11111100 || digit_cath !== 2'b01) begin errors++; $display("FAIL mid_rst_seg got %b/%b exp 11111100/01", digit_seg, digit_cath); end
        checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b/%b exp 0/0", busy, ovf); end
        tick();
        rst = 1'b0;
        tick();
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b11111100) begin errors++; $display("FAIL mid_rst_tens got %b exp 11111100", digit_seg); end
        do_load(8'd12, 1'b0, nb);
        checks++; if (nb != 9) begin errors++; $display("FAIL dec12_busy got %0d exp 9", nb); end
        seek(2'b10, ok);
        checks++; if (!ok || digit_seg !== 8'b01100000) begin errors++; $display("FAIL dec12_tens got %b exp 01100000", digit_seg); end
        seek(2'b01, ok);
        checks++; if (!ok || digit_seg !== 8'b11011010) begin errors++; $display("FAIL dec12_units got %b exp 11011010", digit_seg); end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_blank();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_bcd_scan.md
# seg_bcd_scan

Display back-end for the switch/adder boards: captures a binary result on a load strobe and converts it to two BCD digits with a sequential double-dabble engine, or splits it into two hex nibbles. It then time-multiplexes the two digits onto the shared seven-segment bus. It consumes the adder/selector result directly and owns `digit_seg`/`digit_cath` at the top level. It replaces inline decode/scan logic in top modules.

## Interface
- `IN_W`, 8: binary input width, legal range 1..8; narrower values are zero-extended to 8 bits internally.
- `SCAN_W`, 11: scan counter width; each digit is held for 2^SCAN_W clk cycles.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  IN_W  binary value to display.
- `load`  in  1  single-cycle strobe; accepted only when `busy`=0.
- `hex_mode`  in  1  sampled with `load`. 1 selects hex nibbles; 0 selects decimal.
- `blank_lz`  in  1  live, unregistered control. 1 blanks the tens digit when it is 0.
- `digit_seg`  out  8  segment bus, registered, bit order {a,b,c,d,e,f,g,dp}, active-high.
- `digit_cath`  out  2  digit select, registered. 2'b01 selects the units digit; 2'b10 selects the tens digit.
- `busy`  out  1  conversion in progress.
- `ovf`  out  1  the displayed decimal value exceeds 99.

## Operation
- Reset values:
  - `digit_seg`=8'b11111100 (glyph 0), `digit_cath`=2'b01, `busy`=0, `ovf`=0.
  - Display registers tens=0, units=0; scan phase=0; scan counter=0; FSM in IDLE.
- FSM states:
  - **IDLE**: if `load`=1, capture zero-extended `din` and `hex_mode`. Go to CONV in decimal mode, or to COMMIT in hex mode.
  - **CONV**: runs exactly IN_W iterations, one per cycle. Each iteration first adds 3 to every BCD nibble (hundreds, tens, units) that is ≥5, then shifts {hund,tens,units,bin} left by 1. After the last iteration, go to COMMIT.
  - **COMMIT**: write the display registers, then go to IDLE.
    - Decimal: if hund≠0, set `ovf`=1 and show a dash on both digits; otherwise tens/units come from the BCD result and `ovf`=0.
    - Hex: tens=value[7:4], units=value[3:0], `ovf`=0.
- `busy`=1 in CONV and COMMIT.
- `load` with `busy`=1 is ignored; nothing is queued.
- The display registers hold the previous value throughout a conversion, so no intermediate value is ever shown.
- Glyph table, 0..F: 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110, 11101110, 00111110, 10011100, 01111010, 10011110, 10001110.
  - Dash: 00000010.
  - Blank: 00000000.
- Leading-zero blanking applies in both modes and never when `ovf`=1. The units digit is never blanked.
- Scan:
  - The SCAN_W-bit counter free-runs.
  - When it reaches all-ones, the phase toggles.
  - Phase 0 drives `digit_cath`=2'b01 with the units glyph; phase 1 drives 2'b10 with the tens glyph.
  - `digit_seg` and `digit_cath` update on the same edge, so they are never mismatched.

## Timing
- Load accepted at edge k.
  - Decimal: `busy` is high after edges k through k+IN_W, i.e. IN_W+1 cycles (9 for IN_W=8). The display registers are new after edge k+IN_W+1.
  - Hex: `busy` is high for 1 cycle; the display registers are new after edge k+1.
- `digit_seg` reflects a new display register or a `blank_lz` change one edge later, for the currently scanned digit.
- The phase holds for 2^SCAN_W cycles; the full refresh period is 2^(SCAN_W+1) cycles.
- `load` is sampled on the same edge that the FSM leaves COMMIT; since `busy`=1 at that edge, the strobe is ignored.
- `rst` asserted mid-conversion forces all reset values immediately and discards the captured value.
- `din` changes after capture have no effect.

## Test plan
- Reset, then release with SCAN_W=2:
  - Immediately: `digit_seg`=11111100, `digit_cath`=01, `busy`=0, `ovf`=0.
  - `digit_cath` then alternates 01/10 every 4 cycles.
- Decimal `din`=30, `blank_lz`=0:
  - `busy` is high for exactly 9 cycles.
  - Units phase shows 11111100; tens phase shows 11110010.
- Hex `din`=8'h1E:
  - `busy` is high for 1 cycle.
  - Tens shows 01100000; units shows 10011110.
- Decimal `din`=7 with `blank_lz`=1:
  - Tens shows 00000000; units shows 11100000.
  - Dropping `blank_lz` shows 11111100 on tens one edge later.
- Decimal `din`=150:
  - `ovf`=1 and both digits show 00000010.
  - A subsequent load of 42 clears `ovf` and shows 01100110 (tens) and 11011010 (units).
- Load and reset during conversion:
  - Load 25, then pulse `load` with 99 during `busy`: the display ends at 25.
  - Load 88, then assert `rst` at the 4th busy cycle: all outputs return to reset values, and the next load of 12 shows 12 correctly.
